// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode codes, control-state encoding and beat indices.
// Imported by the beat generator / instruction decoder.
package cpu_pkg;

   localparam int unsigned NBEATS = 8;
   localparam int unsigned BW     = 3;
   localparam int unsigned OPW    = 3;

   localparam logic [OPW-1:0] OP_LD   = 3'd0;
   localparam logic [OPW-1:0] OP_ADD  = 3'd1;
   localparam logic [OPW-1:0] OP_SUB  = 3'd2;
   localparam logic [OPW-1:0] OP_AND  = 3'd3;
   localparam logic [OPW-1:0] OP_OR   = 3'd4;
   localparam logic [OPW-1:0] OP_SHL  = 3'd5;
   localparam logic [OPW-1:0] OP_XOR  = 3'd6;
   localparam logic [OPW-1:0] OP_HALT = 3'd7;

   localparam logic [BW-1:0] B_FETCH_LAST = 3'd2;
   localparam logic [BW-1:0] B_HALT_LAST  = 3'd3;
   localparam logic [BW-1:0] B_LD_LAST    = 3'd6;
   localparam logic [BW-1:0] B_ALU_LAST   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Final execute beat of an instruction, by opcode.
   function automatic logic [BW-1:0] last_beat(input logic [OPW-1:0] op);
      case (op)
         OP_LD:   return B_LD_LAST;
         OP_HALT: return B_HALT_LAST;
         default: return B_ALU_LAST;
      endcase
   endfunction

endpackage

// File: rtl/timing_decoder_if.sv
// Control bus between the sequencer and the rest of the model CPU:
// run/step controls and DR in, one-hot beat and opcode lines out.
interface timing_decoder_if #(
   parameter int unsigned DW = 8
);
   logic          start;
   logic          step_mode;
   logic          step;
   logic [DW-1:0] dr_in;

   logic T0, T1, T2, T3, T4, T5, T6, T7;
   logic LD, ADD, SUB, AND, OR, SHL, XOR, HALT;
   logic running;
   logic halted;
   logic instr_done;

   modport master (
      output start, step_mode, step, dr_in,
      input  T0, T1, T2, T3, T4, T5, T6, T7,
      input  LD, ADD, SUB, AND, OR, SHL, XOR, HALT,
      input  running, halted, instr_done
   );

   modport slave (
      input  start, step_mode, step, dr_in,
      output T0, T1, T2, T3, T4, T5, T6, T7,
      output LD, ADD, SUB, AND, OR, SHL, XOR, HALT,
      output running, halted, instr_done
   );
endinterface

// File: rtl/timing_decoder.sv
// Beat generator and instruction decoder: one-hot T0..T7 beats, one-hot opcode lines,
// run/halt and single-step sequencing. All outputs are registered.
module timing_decoder
   import cpu_pkg::*;
#(
   parameter int unsigned DW     = 8,
   parameter int unsigned OP_MSB = 7
) (
   input  logic            clk,
   input  logic            rst,
   timing_decoder_if.slave bus
);

   state_t            state, state_n;
   logic [BW-1:0]     beat, beat_n;
   logic [OPW-1:0]    op, op_n;
   logic              op_valid, op_valid_n;
   logic              adv;
   logic              done_n;
   logic [NBEATS-1:0] t_n, t_q;
   logic [NBEATS-1:0] opl_n, opl_q;
   logic              running_q, halted_q, done_q;
   logic              unused_dr;

   assign unused_dr = ^bus.dr_in;

   // Next-state, beat and opcode sequencing; output decode is taken from the next values.
   always_comb begin
      state_n    = state;
      beat_n     = beat;
      op_n       = op;
      op_valid_n = op_valid;
      done_n     = 1'b0;
      t_n        = '0;
      opl_n      = '0;
      adv        = !bus.step_mode || bus.step;

      case (state)
         ST_IDLE, ST_HALTED: begin
            if (bus.start) begin
               state_n    = ST_RUN;
               beat_n     = '0;
               op_valid_n = 1'b0;
            end
         end
         ST_RUN: begin
            if (adv) begin
               if (beat == B_FETCH_LAST) begin
                  op_n       = bus.dr_in[OP_MSB -: OPW];
                  op_valid_n = 1'b1;
                  beat_n     = beat + BW'(1);
               end else if (op_valid && (beat == last_beat(op))) begin
                  done_n     = 1'b1;
                  op_valid_n = 1'b0;
                  beat_n     = '0;
                  if (op == OP_HALT) begin
                     state_n = ST_HALTED;
                  end
               end else begin
                  beat_n = beat + BW'(1);
               end
            end
         end
         default: begin
            state_n    = ST_IDLE;
            beat_n     = '0;
            op_valid_n = 1'b0;
         end
      endcase

      if (state_n == ST_RUN) begin
         t_n[beat_n] = 1'b1;
         if (op_valid_n) begin
            opl_n[op_n] = 1'b1;
         end
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         beat      <= '0;
         op        <= OP_LD;
         op_valid  <= 1'b0;
         t_q       <= '0;
         opl_q     <= '0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_n;
         beat      <= beat_n;
         op        <= op_n;
         op_valid  <= op_valid_n;
         t_q       <= t_n;
         opl_q     <= opl_n;
         running_q <= (state_n == ST_RUN);
         halted_q  <= (state_n == ST_HALTED);
         done_q    <= done_n;
      end
   end

   assign bus.T0 = t_q[0];
   assign bus.T1 = t_q[1];
   assign bus.T2 = t_q[2];
   assign bus.T3 = t_q[3];
   assign bus.T4 = t_q[4];
   assign bus.T5 = t_q[5];
   assign bus.T6 = t_q[6];
   assign bus.T7 = t_q[7];

   assign bus.LD   = opl_q[OP_LD];
   assign bus.ADD  = opl_q[OP_ADD];
   assign bus.SUB  = opl_q[OP_SUB];
   assign bus.AND  = opl_q[OP_AND];
   assign bus.OR   = opl_q[OP_OR];
   assign bus.SHL  = opl_q[OP_SHL];
   assign bus.XOR  = opl_q[OP_XOR];
   assign bus.HALT = opl_q[OP_HALT];

   assign bus.running    = running_q;
   assign bus.halted     = halted_q;
   assign bus.instr_done = done_q;

endmodule

// File: tb/tb_timing_decoder.sv
// Self-checking bench for timing_decoder: directed scenarios plus randomized stepping,
// compared against an instruction-position reference model.
module tb_timing_decoder;

   logic clk = 1'b0;
   logic rst;

   timing_decoder_if #(.DW(8)) bus ();

   timing_decoder #(.DW(8), .OP_MSB(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: 0 idle, 1 run, 2 halted; position within the instruction.
   int         m_mode = 0;
   int         m_pos  = 0;
   int         m_op   = -1;
   logic       m_done = 1'b0;
   logic [2:0] next_op = 3'd0;

   function automatic int ilen(input int op);
      if (op == 0) return 7;
      if (op == 7) return 4;
      return 8;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_mode = 0; m_pos = 0; m_op = -1; m_done = 1'b0;
         return;
      end
      m_done = 1'b0;
      if (m_mode != 1) begin
         if (bus.start) begin
            m_mode = 1; m_pos = 0; m_op = -1;
         end
      end else if (!bus.step_mode || bus.step) begin
         if (m_pos == 2) begin
            m_op  = int'(bus.dr_in[7:5]);
            m_pos = 3;
         end else if (m_pos == ilen(m_op) - 1) begin
            m_done = 1'b1;
            m_pos  = 0;
            if (m_op == 7) m_mode = 2;
            m_op = -1;
         end else begin
            m_pos = m_pos + 1;
         end
      end
   endtask

   function automatic logic [18:0] obs_vec();
      return {bus.T7, bus.T6, bus.T5, bus.T4, bus.T3, bus.T2, bus.T1, bus.T0,
              bus.HALT, bus.XOR, bus.SHL, bus.OR, bus.AND, bus.SUB, bus.ADD, bus.LD,
              bus.running, bus.halted, bus.instr_done};
   endfunction

   function automatic logic [18:0] exp_vec();
      logic [7:0] t;
      logic [7:0] o;
      t = 8'd0;
      o = 8'd0;
      if (m_mode == 1) begin
         t = 8'd1 << m_pos;
         if (m_op >= 0) o = 8'd1 << m_op;
      end
      return {t, o, m_mode == 1, m_mode == 2, m_done};
   endfunction

   // Drive DR (carrying next_op when the fetch completes), advance the model, clock once.
   task automatic tick();
      if (m_mode == 1 && m_pos == 2) bus.dr_in = {next_op, 5'($urandom)};
      else                           bus.dr_in = 8'($urandom);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; bus.start = 1'b0; bus.step = 1'b0; bus.step_mode = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b1; bus.step_mode = 1'($urandom); bus.step = 1'($urandom);
      tick(); tick();
      checks++;
      if (obs_vec() !== 19'd0) begin
         failures++; $display("FAIL reset_with_start got=%h exp=%h", obs_vec(), 19'd0);
      end
      rst = 1'b0; bus.start = 1'b0;
      tick();
      checks++;
      if (obs_vec() !== 19'd0) begin
         failures++; $display("FAIL idle_hold got=%h exp=%h", obs_vec(), 19'd0);
      end
   endtask

   task automatic test_seq(input logic [2:0] op, input int len, input string name);
      logic [18:0] e;
      do_reset();
      next_op = op;
      pulse_start();
      for (int i = 0; i < len; i++) begin
         e = {8'd1 << i, (i >= 3) ? (8'd1 << op) : 8'd0, 1'b1, 1'b0, 1'b0};
         checks++;
         if (obs_vec() !== e) begin
            failures++; $display("FAIL %s beat=%0d got=%h exp=%h", name, i, obs_vec(), e);
         end
         tick();
      end
      e = {8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
      checks++;
      if (obs_vec() !== e) begin
         failures++; $display("FAIL %s_done got=%h exp=%h", name, obs_vec(), e);
      end
   endtask

   task automatic test_halt();
      logic [18:0] e;
      do_reset();
      next_op = 3'd7;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         e = {8'd1 << i, (i == 3) ? 8'h80 : 8'h00, 1'b1, 1'b0, 1'b0};
         checks++;
         if (obs_vec() !== e) begin
            failures++; $display("FAIL halt beat=%0d got=%h exp=%h", i, obs_vec(), e);
         end
         if (i == 3) bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
      end
      e = {8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs_vec() !== e) begin
         failures++; $display("FAIL halt_enter got=%h exp=%h", obs_vec(), e);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs_vec() !== {16'h0000, 3'b010}) begin
            failures++; $display("FAIL halted_hold c=%0d got=%h exp=%h", i, obs_vec(), {16'h0000, 3'b010});
         end
      end
      next_op = 3'd1;
      pulse_start();
      checks++;
      if (obs_vec() !== {8'h01, 8'h00, 3'b100}) begin
         failures++; $display("FAIL halt_restart got=%h exp=%h", obs_vec(), {8'h01, 8'h00, 3'b100});
      end
   endtask

   task automatic test_step();
      int         dones;
      logic [7:0] et;
      do_reset();
      next_op = 3'd4;
      bus.step_mode = 1'b1;
      pulse_start();
      for (int c = 0; c < 18; c++) begin
         bus.step = (c % 3 == 2);
         tick();
         et = 8'd1 << ((c + 1) / 3);
         checks++;
         if (obs_vec()[18:11] !== et || obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL step_hold c=%0d got=%h exp=%h", c, obs_vec(), {et, exp_vec()[10:0]});
         end
      end
      dones = 0;
      bus.step = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.instr_done) dones++;
      end
      bus.step = 1'b0;
      checks++;
      if (obs_vec()[18:11] !== 8'h04 || dones != 1) begin
         failures++; $display("FAIL step_burst got_t=%h dones=%0d exp_t=04 dones=1", obs_vec()[18:11], dones);
      end
      bus.step_mode = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      do_reset();
      next_op = 3'd6;
      pulse_start();
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         if (bus.T5) begin
            seen = 1'b1;
         end else begin
            bus.start = bus.T4;
            tick();
            bus.start = 1'b0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
               failures++; $display("FAIL xor_run c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
         end
      end
      checks++;
      if (!seen || bus.XOR !== 1'b1) begin
         failures++; $display("FAIL xor_reach_t5 got_t5=%b xor=%b exp=1 1", bus.T5, bus.XOR);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (obs_vec() !== 19'd0) begin
         failures++; $display("FAIL reset_mid got=%h exp=%h", obs_vec(), 19'd0);
      end
      tick();
      checks++;
      if (obs_vec() !== 19'd0) begin
         failures++; $display("FAIL reset_mid_after got=%h exp=%h", obs_vec(), 19'd0);
      end
   endtask

   task automatic test_back_to_back();
      int order [8];
      int tmp, j, dones;
      for (int i = 0; i < 8; i++) order[i] = i;
      for (int i = 6; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      do_reset();
      next_op = 3'(order[0]);
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         next_op = 3'(order[k]);
         dones = 0;
         for (int c = 0; c < ilen(order[k]); c++) begin
            tick();
            if (bus.instr_done) dones++;
            checks++;
            if ($countones(obs_vec()[18:11]) > 1 || $countones(obs_vec()[10:3]) > 1 ||
                obs_vec() !== exp_vec()) begin
               failures++; $display("FAIL b2b op=%0d c=%0d got=%h exp=%h", order[k], c, obs_vec(), exp_vec());
            end
         end
         checks++;
         if (dones != 1 || bus.instr_done !== 1'b1) begin
            failures++; $display("FAIL b2b_done op=%0d dones=%0d last=%b exp=1 1", order[k], dones, bus.instr_done);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst           = ($urandom_range(0, 99) == 0);
         bus.start     = ($urandom_range(0, 9) == 0);
         bus.step_mode = ($urandom_range(0, 3) != 0) ? bus.step_mode : 1'($urandom);
         bus.step      = 1'($urandom);
         next_op       = 3'($urandom);
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
         end
      end
      rst = 1'b0; bus.start = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0; bus.dr_in = 8'h00;
      @(posedge clk);
      #1;
      test_reset();
      test_seq(3'd1, 8, "add_seq");
      test_seq(3'd0, 7, "ld_seq");
      test_halt();
      test_step();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
